// File: rtl/exp_pkg.sv
// Shared constants and types for the exponent stage and its frame accumulator.
package exp_pkg;
  localparam int DATA_W = 20;
  localparam int SUM_W  = 28;
  localparam int CNT_W  = 8;
  localparam int FRAC_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } inState_t;
endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: a carry out of W bits clamps the result to all-ones.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[W];
  assign sum = raw[W] ? '1 : raw[W-1:0];
endmodule

// File: rtl/exp_sum_acc.sv
// Frame accumulator for 16.4 exponent samples: saturating per-frame sum and count,
// presented on a one-deep valid/ready register; results that cannot be held are dropped.
//   state | meaning
//   IDLE  | no partial frame, acc/cnt are zero
//   ACCUM | partial frame held in acc/cnt
module exp_sum_acc
  import exp_pkg::*;
#(
  parameter int DATA_W = exp_pkg::DATA_W,
  parameter int SUM_W  = exp_pkg::SUM_W,
  parameter int CNT_W  = exp_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  input  logic              iLast,
  output logic [SUM_W-1:0]  oSum,
  output logic [CNT_W-1:0]  oCount,
  output logic              oSat,
  output logic              oSumValid,
  input  logic              oSumReady,
  output logic              oDropErr
);
  inState_t         state, nextState;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accSat;

  logic [SUM_W-1:0] accOperand, sumNext;
  logic [CNT_W-1:0] cntOperand, cntNext;
  logic             sumOvf, cntOvf, frameDone, frameSat, loadOk;

  // IDLE forces a zero operand so a first sample never picks up stale partials
  assign accOperand = (state == ACCUM) ? acc : '0;
  assign cntOperand = (state == ACCUM) ? cnt : '0;

  sat_add #(.W(SUM_W)) uSumAdd (
    .a   (accOperand),
    .b   (SUM_W'(iData)),
    .sum (sumNext),
    .ovf (sumOvf)
  );

  sat_add #(.W(CNT_W)) uCntAdd (
    .a   (cntOperand),
    .b   (CNT_W'(1)),
    .sum (cntNext),
    .ovf (cntOvf)
  );

  assign frameDone = iDataValid & iLast;
  assign frameSat  = accSat | sumOvf | cntOvf;
  assign loadOk    = ~oSumValid | oSumReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (iDataValid) nextState = iLast ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      accSat <= 1'b0;
    end else if (iDataValid) begin
      if (iLast) begin
        acc    <= '0;
        cnt    <= '0;
        accSat <= 1'b0;
      end else begin
        acc    <= sumNext;
        cnt    <= cntNext;
        accSat <= (state == ACCUM) ? frameSat : (sumOvf | cntOvf);
      end
    end
  end

  // A held result blocks a new one unless it is being taken this same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oSum      <= '0;
      oCount    <= '0;
      oSat      <= 1'b0;
      oSumValid <= 1'b0;
      oDropErr  <= 1'b0;
    end else if (frameDone) begin
      if (loadOk) begin
        oSum      <= sumNext;
        oCount    <= cntNext;
        oSat      <= frameSat;
        oSumValid <= 1'b1;
      end else begin
        oDropErr  <= 1'b1;
      end
    end else if (oSumValid && oSumReady) begin
      oSumValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exp_sum_acc.sv
// Randomised and directed checks of exp_sum_acc against a frame-level reference model.
module tb_exp_sum_acc;
  localparam longint SUM_MAX = (64'd1 << 28) - 1;
  localparam int     CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] iData = '0;
  logic        iDataValid = 1'b0;
  logic        iLast = 1'b0;
  logic        oSumReady = 1'b0;
  logic [27:0] oSum;
  logic [7:0]  oCount;
  logic        oSat, oSumValid, oDropErr;

  logic [19:0] nData = '0;
  logic        nDataValid = 1'b0;
  logic        nLast = 1'b0;
  logic [19:0] nSum;
  logic [7:0]  nCount;
  logic        nSat, nSumValid, nDropErr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exp_sum_acc dut (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iDataValid(iDataValid), .iLast(iLast),
    .oSum(oSum), .oCount(oCount), .oSat(oSat), .oSumValid(oSumValid),
    .oSumReady(oSumReady), .oDropErr(oDropErr)
  );

  exp_sum_acc #(.SUM_W(20)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .iData(nData), .iDataValid(nDataValid), .iLast(nLast),
    .oSum(nSum), .oCount(nCount), .oSat(nSat), .oSumValid(nSumValid),
    .oSumReady(1'b1), .oDropErr(nDropErr)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true unbounded frame sum/length, clamped only when a frame completes
  longint mAcc, mSum, fSum;
  int     mCnt, mCount, fCnt;
  bit     mValid, mSat, mDrop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mAcc = 0; mCnt = 0; mValid = 0; mSum = 0; mCount = 0; mSat = 0; mDrop = 0;
    end else begin
      if (iDataValid && iLast) begin
        fSum = mAcc + iData;
        fCnt = mCnt + 1;
        mAcc = 0;
        mCnt = 0;
        if (!mValid || oSumReady) begin
          mValid = 1;
          mSum   = (fSum > SUM_MAX) ? SUM_MAX : fSum;
          mCount = (fCnt > CNT_MAX) ? CNT_MAX : fCnt;
          mSat   = (fSum > SUM_MAX) || (fCnt > CNT_MAX);
        end else begin
          mDrop = 1;
        end
      end else begin
        if (iDataValid) begin
          mAcc += iData;
          mCnt += 1;
        end
        if (mValid && oSumReady) mValid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("oSumValid", oSumValid, mValid);
      check("oDropErr", oDropErr, mDrop);
      if (mValid) begin
        check("oSum", oSum, mSum);
        check("oCount", oCount, mCount);
        check("oSat", oSat, mSat);
      end
    end
  end

  task automatic step(input bit v, input logic [19:0] d, input bit l, input bit r);
    iDataValid = v;
    iData = d;
    iLast = l;
    oSumReady = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("reset oSum", oSum, 0);
    check("reset oSumValid", oSumValid, 0);
    check("reset oDropErr", oDropErr, 0);
    rst_n = 1'b1;

    // four-sample frame
    step(1, 20'h00010, 0, 1);
    step(1, 20'h00020, 0, 1);
    step(1, 20'h00030, 0, 1);
    step(1, 20'h00040, 1, 1);
    check("t1 valid", oSumValid, 1);
    check("t1 sum", oSum, 28'h00000A0);
    check("t1 count", oCount, 4);
    check("t1 sat", oSat, 0);
    step(0, 0, 0, 1);
    check("t1 valid pulse", oSumValid, 0);

    // single-beat frame then gaps
    step(1, 20'hFFFFF, 1, 1);
    check("t2 sum", oSum, 28'h00FFFFF);
    check("t2 count", oCount, 1);
    repeat (4) step(0, 20'h12345, 1, 1);
    check("t2 no extra valid", oSumValid, 0);

    // 300-sample frame: 300*0xFFFFF exceeds 2^28-1, so both fields clamp
    for (int i = 0; i < 299; i++) step(1, 20'hFFFFF, 0, 1);
    step(1, 20'hFFFFF, 1, 1);
    check("t3 count", oCount, 255);
    check("t3 sum", oSum, 28'hFFFFFFF);
    check("t3 sat", oSat, 1);

    // narrow instance: two max samples overflow a 20-bit sum
    nDataValid = 1; nData = 20'hFFFFF; nLast = 0;
    @(posedge clk); #1;
    nLast = 1;
    @(posedge clk); #1;
    nDataValid = 0; nLast = 0;
    check("narrow sum", nSum, 20'hFFFFF);
    check("narrow sat", nSat, 1);
    check("narrow count", nCount, 2);
    step(0, 0, 0, 1);

    // A held, B dropped
    step(1, 20'h00100, 0, 0);
    step(1, 20'h00200, 1, 0);
    step(1, 20'h00007, 1, 0);
    check("t4 A held sum", oSum, 28'h0000300);
    check("t4 A held count", oCount, 2);
    check("t4 drop", oDropErr, 1);
    repeat (3) step(0, 0, 0, 0);
    check("t4 A stable", oSum, 28'h0000300);
    step(0, 0, 0, 1);
    check("t4 drop sticky", oDropErr, 1);
    doReset();
    check("t4 drop cleared", oDropErr, 0);

    // A held, B loads while A transfers
    step(1, 20'h00100, 1, 0);
    step(0, 0, 0, 0);
    step(1, 20'h00009, 1, 1);
    check("t4b B sum", oSum, 28'h0000009);
    check("t4b B valid", oSumValid, 1);
    check("t4b no drop", oDropErr, 0);
    step(0, 0, 0, 1);

    // reset mid-frame with a result held
    step(1, 20'h00050, 1, 0);
    step(1, 20'h00011, 0, 0);
    step(1, 20'h00022, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5 sum", oSum, 0);
    check("t5 count", oCount, 0);
    check("t5 sat", oSat, 0);
    check("t5 valid", oSumValid, 0);
    check("t5 drop", oDropErr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 20'h00005, 0, 1);
    step(1, 20'h00006, 0, 1);
    step(1, 20'h00007, 1, 1);
    check("t5 post sum", oSum, 28'h0000012);
    check("t5 post count", oCount, 3);

    // random traffic, including a phase of long frames
    for (int c = 0; c < 3000; c++) begin
      bit longMode;
      longMode = (c >= 1200) && (c < 2200);
      step(($urandom % 4) != 0,
           ($urandom % 3 == 0) ? 20'hFFFFF : 20'($urandom_range(0, 20'hFFFFF)),
           longMode ? (($urandom % 300) == 0) : (($urandom % 6) == 0),
           ($urandom % 3) != 0);
      if (c == 2500) doReset();
    end
    step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
